// File: rtl/handshake_const_rr_arbiter.sv
// handshake_const_rr_arbiter
//   Round-robin arbiter that shares one registered constant-emitting output
//   channel between NUM_REQ control-token requesters. A granted token puts
//   the requester's fixed constant on outs, tagged with its index on outs_id.
//   Optional feature macro: HANDSHAKE_CONST_ARB_COUNT_EN adds a 16-bit
//   issued_count of output transfers.
module handshake_const_rr_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 2,
    parameter logic [NUM_REQ*DATA_WIDTH-1:0] CONST_VALUES =
        96'h0000_0009_0000_0003_0000_0007
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    ctrl_valid,
    output logic [NUM_REQ-1:0]    ctrl_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic [ID_WIDTH-1:0]   outs_id,
    output logic                  outs_valid,
    input  logic                  outs_ready
`ifdef HANDSHAKE_CONST_ARB_COUNT_EN
    ,
    output logic [15:0]           issued_count
`endif
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [DATA_WIDTH-1:0] const_tab [NUM_REQ];
    logic [PTR_W-1:0]      rr_ptr;
    logic [PTR_W-1:0]      grant_idx;
    logic [PTR_W-1:0]      next_ptr;
    logic [NUM_REQ-1:0]    grant;
    logic                  any_grant;
    logic                  load;

    // Unpack the flattened constants into one slot per requester.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_const
        assign const_tab[i] = CONST_VALUES[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // The slot can take a new token when empty or being drained this cycle.
    assign load = !outs_valid || outs_ready;

    // Rotating priority search: start at rr_ptr, ascend with wrap, first valid wins.
    always_comb begin
        int idx;
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!any_grant && ctrl_valid[PTR_W'(idx)]) begin
                grant[PTR_W'(idx)] = 1'b1;
                grant_idx          = PTR_W'(idx);
                any_grant          = 1'b1;
            end
        end
    end

    // Priority moves to the requester just after the winner, wrapping to 0.
    assign next_ptr = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    // Only the winner sees ready, and only when the slot can accept.
    assign ctrl_ready = load ? grant : '0;

    // Output slot and round-robin pointer; both hold during a stall.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (!rst) begin
            outs       <= '0;
            outs_id    <= '0;
            outs_valid <= 1'b0;
            rr_ptr     <= '0;
        end else if (load) begin
            if (any_grant) begin
                outs       <= const_tab[grant_idx];
                outs_id    <= ID_WIDTH'(grant_idx);
                outs_valid <= 1'b1;
                rr_ptr     <= next_ptr;
            end else begin
                outs_valid <= 1'b0;
            end
        end
    end

`ifdef HANDSHAKE_CONST_ARB_COUNT_EN
    // Count completed output transfers; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issued_count <= '0;
        end else if (outs_valid && outs_ready) begin
            issued_count <= issued_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_handshake_const_rr_arbiter.sv
// Testbench for handshake_const_rr_arbiter (NUM_REQ=3, DATA_WIDTH=4,
// constants 7/3/9). A reference model predicts each grant and pushes the
// expected output into a scoreboard queue, popped when the output transfers.
module tb_handshake_const_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] ctrl_valid;
    logic [2:0] ctrl_ready;
    logic [3:0] outs;
    logic [1:0] outs_id;
    logic       outs_valid;
    logic       outs_ready;
`ifdef HANDSHAKE_CONST_ARB_COUNT_EN
    logic [15:0] issued_count;
`endif

    handshake_const_rr_arbiter #(
        .NUM_REQ     (3),
        .DATA_WIDTH  (4),
        .ID_WIDTH    (2),
        .CONST_VALUES({4'h9, 4'h3, 4'h7})
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ctrl_valid  (ctrl_valid),
        .ctrl_ready  (ctrl_ready),
        .outs        (outs),
        .outs_id     (outs_id),
        .outs_valid  (outs_valid),
        .outs_ready  (outs_ready)
`ifdef HANDSHAKE_CONST_ARB_COUNT_EN
        ,
        .issued_count(issued_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] data;
        logic [1:0] id;
    } exp_t;

    logic [3:0] cv_tab [3] = '{4'h7, 4'h3, 4'h9};

    exp_t        sb_q [$];
    int          m_ptr   = 0;
    logic        m_full  = 1'b0;
    logic [15:0] m_count = '0;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs at negedge, compare against the model,
    // then advance the model to what the next rising edge should produce.
    task automatic step(input logic [2:0] v, input logic r);
        logic       exp_load;
        logic [2:0] exp_grant;
        int         g;
        @(negedge clk);
        ctrl_valid = v;
        outs_ready = r;
        #1;
        exp_load  = !m_full || r;
        exp_grant = '0;
        g         = -1;
        for (int k = 0; k < 3; k++) begin
            int idx;
            idx = (m_ptr + k) % 3;
            if (g < 0 && v[idx]) g = idx;
        end
        if (g >= 0) exp_grant[g] = 1'b1;
        check("ctrl_ready", 32'(ctrl_ready), exp_load ? 32'(exp_grant) : 32'd0);
        check("outs_valid", 32'(outs_valid), 32'(m_full));
`ifdef HANDSHAKE_CONST_ARB_COUNT_EN
        check("issued_count", 32'(issued_count), 32'(m_count));
`endif
        if (m_full && sb_q.size() > 0) begin
            check("outs", 32'(outs), 32'(sb_q[0].data));
            check("outs_id", 32'(outs_id), 32'(sb_q[0].id));
            if (r) begin
                void'(sb_q.pop_front());
                m_count = m_count + 16'd1;
            end
        end
        if (exp_load && g >= 0) begin
            sb_q.push_back('{data: cv_tab[g], id: 2'(g)});
            m_ptr  = (g + 1) % 3;
            m_full = 1'b1;
        end else if (r) begin
            m_full = 1'b0;
        end
    endtask

    initial begin
        rst        = 1'b0;
        ctrl_valid = '0;
        outs_ready = 1'b0;
        #12;
        check("rst_outs_valid", 32'(outs_valid), 32'd0);
        check("rst_outs", 32'(outs), 32'd0);
        check("rst_outs_id", 32'(outs_id), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Single token from requester 1, drain, then all-valid grants 2 first.
        step(3'b010, 1'b1);
        step(3'b000, 1'b1);
        step(3'b000, 1'b1);
        step(3'b111, 1'b1);

        // Continuous contention, no bubbles.
        repeat (6) step(3'b111, 1'b1);

        // Put id 0 in the slot, then backpressure with 1 and 2 requesting.
        step(3'b001, 1'b1);
        repeat (4) step(3'b110, 1'b0);
        step(3'b110, 1'b1);
        step(3'b110, 1'b1);

        // Sparse wrap: pointer at 1, only requester 0 valid.
        step(3'b111, 1'b1);
        step(3'b001, 1'b1);
        step(3'b010, 1'b1);
        step(3'b000, 1'b1);

        // Reset asserted mid-stall, between clock edges.
        step(3'b100, 1'b1);
        step(3'b000, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_outs_valid", 32'(outs_valid), 32'd0);
        check("midrst_outs", 32'(outs), 32'd0);
        check("midrst_outs_id", 32'(outs_id), 32'd0);
        sb_q.delete();
        m_ptr   = 0;
        m_full  = 1'b0;
        m_count = '0;
        @(negedge clk);
        rst = 1'b1;
        step(3'b111, 1'b1);
        step(3'b000, 1'b1);
        step(3'b000, 1'b1);

        // Random traffic with random backpressure.
        for (int i = 0; i < 60; i++) begin
            step(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end
        step(3'b000, 1'b1);
        step(3'b000, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
